// File: rtl/m2p_serializer_if.sv
// -----------------------------------------------------------------------------
// m2p_serializer_if
// Bundles the method-call side and the output pipe side of m2p_serializer.
//
//   method_ena   [NCHAN]            per-channel call strobe
//   method_data  [NCHAN*PAYLOAD_W]  channel i at [i*PAYLOAD_W +: PAYLOAD_W]
//   method_rdy   [NCHAN]            channel i holding register is empty
//   pipe_enq_ena                    output beat valid
//   pipe_enq_v   [BEAT_W]           output beat data
//   pipe_enq_rdy                    downstream accepts the beat
//   overflow                        sticky: call dropped on a busy channel
//
// The slave modport is the serializer's view; master is the view of whoever
// makes calls and consumes the pipe.
// -----------------------------------------------------------------------------
interface m2p_serializer_if #(
   parameter int NCHAN     = 3,
   parameter int BEAT_W    = 32,
   parameter int PAYLOAD_W = 128
);
   logic [NCHAN-1:0]           method_ena;
   logic [NCHAN*PAYLOAD_W-1:0] method_data;
   logic [NCHAN-1:0]           method_rdy;
   logic                       pipe_enq_ena;
   logic [BEAT_W-1:0]          pipe_enq_v;
   logic                       pipe_enq_rdy;
   logic                       overflow;

   modport master (
      output method_ena, method_data, pipe_enq_rdy,
      input  method_rdy, pipe_enq_ena, pipe_enq_v, overflow
   );

   modport slave (
      input  method_ena, method_data, pipe_enq_rdy,
      output method_rdy, pipe_enq_ena, pipe_enq_v, overflow
   );
endinterface

// File: rtl/m2p_serializer.sv
// -----------------------------------------------------------------------------
// m2p_serializer
// Method-to-pipe serializer. Each of NCHAN method channels has a one-deep
// holding register. Pending calls are granted round-robin and streamed out on
// a BEAT_W-wide ready/valid pipe as one header beat followed by CHAN_WORDS[i]
// payload beats, lowest word first.
//
// Header beat: [15:0] channel index, [31:16] total beats (payload + 1),
// all other bits zero.
//
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  m2p_serializer_if.slave (method_ena/method_data/method_rdy,
//        pipe_enq_ena/pipe_enq_v/pipe_enq_rdy, overflow)
//
// All pipe outputs come straight from registers; there is no combinational
// path from any input to pipe_enq_ena / pipe_enq_v.
// -----------------------------------------------------------------------------
module m2p_serializer #(
   parameter int                 NCHAN      = 3,
   parameter int                 BEAT_W     = 32,
   parameter int                 PAYLOAD_W  = 128,
   parameter logic [NCHAN*8-1:0] CHAN_WORDS = {8'd3, 8'd1, 8'd1}
) (
   input logic             CLK,
   input logic             RST,
   m2p_serializer_if.slave bus
);

   localparam int SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     last_q, last_d;
   logic [7:0]           cnt_q, cnt_d;      // payload words already loaded
   logic                 ena_q, ena_d;
   logic [BEAT_W-1:0]    v_q, v_d;
   logic [NCHAN-1:0]     pend_q, pend_d;
   logic                 ovf_q, ovf_d;
   logic [NCHAN-1:0]     cap;
   logic [PAYLOAD_W-1:0] hold_q [NCHAN];

   logic                 grant_found;
   logic [SEL_W-1:0]     grant_idx;

   function automatic logic [7:0] chan_words(input logic [SEL_W-1:0] c);
      return CHAN_WORDS[c*8 +: 8];
   endfunction

   function automatic logic [BEAT_W-1:0] make_header(input logic [SEL_W-1:0] c);
      logic [BEAT_W-1:0] h;
      h        = '0;
      h[15:0]  = 16'(c);
      h[31:16] = {8'd0, chan_words(c)} + 16'd1;
      return h;
   endfunction

   // Round-robin: lowest pending index above last, else wrap to lowest
   // pending index at or below last.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (!grant_found && pend_q[i] && (SEL_W'(i) > last_q)) begin
            grant_found = 1'b1;
            grant_idx   = SEL_W'(i);
         end
      end
      for (int i = 0; i < NCHAN; i++) begin
         if (!grant_found && pend_q[i] && (SEL_W'(i) <= last_q)) begin
            grant_found = 1'b1;
            grant_idx   = SEL_W'(i);
         end
      end
   end

   // Next-state: capture, arbitration and beat sequencing
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ena_d   = ena_q;
      v_d     = v_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      cap     = '0;

      for (int i = 0; i < NCHAN; i++) begin
         if (bus.method_ena[i]) begin
            if (!pend_q[i]) begin
               cap[i]    = 1'b1;
               pend_d[i] = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               v_d     = make_header(grant_idx);
               ena_d   = 1'b1;
               sel_d   = grant_idx;
               cnt_d   = 8'd0;
               state_d = SEND;
            end else begin
               ena_d = 1'b0;
            end
         end
         SEND: begin
            // Without a handshake everything holds, keeping the beat stable.
            if (ena_q && bus.pipe_enq_rdy) begin
               if (cnt_q < chan_words(sel_q)) begin
                  v_d   = hold_q[sel_q][cnt_q*BEAT_W +: BEAT_W];
                  cnt_d = cnt_q + 8'd1;
               end else begin
                  // The selected channel is pending, so no capture above can
                  // collide with this clear; a same-cycle strobe overflowed.
                  pend_d[sel_q] = 1'b0;
                  last_d        = sel_q;
                  ena_d         = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage boundary: control and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         sel_q   <= '0;
         last_q  <= SEL_W'(NCHAN - 1);
         cnt_q   <= 8'd0;
         ena_q   <= 1'b0;
         v_q     <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ena_q   <= ena_d;
         v_q     <= v_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   // Stage boundary: payload holding registers (qualified by pending, no reset)
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NCHAN; i++) begin
         if (cap[i]) begin
            hold_q[i] <= bus.method_data[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

   assign bus.method_rdy   = ~pend_q;
   assign bus.pipe_enq_ena = ena_q;
   assign bus.pipe_enq_v   = v_q;
   assign bus.overflow     = ovf_q;

endmodule

// File: doc/m2p_serializer.md
Name: m2p_serializer

Overview:
- Parametrised method-to-pipe serializer. NCHAN method channels, each with a fixed-length payload.
- Each accepted method call is captured into a one-deep per-channel holding register.
- Pending calls are arbitrated round-robin and streamed out as a multi-beat message on a BEAT_W-wide ready/valid pipe: one header beat, then the payload beats.
- Generalises the single-beat wide-word indication packer: narrow output, per-channel buffering, fair arbitration and backpressure-safe sequencing.

Parameters:
- NCHAN, 3, number of method channels (1..16).
- BEAT_W, 32, output beat width in bits; must be at least 32.
- PAYLOAD_W, 128, per-channel payload input width; a multiple of BEAT_W.
- CHAN_WORDS, {8'd3,8'd1,8'd1}, packed NCHAN*8 vector. Byte i is channel i's payload beat count, 0..PAYLOAD_W/BEAT_W.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- method_ena  in  NCHAN  per-channel call strobe; honoured only when the matching method_rdy is 1.
- method_data  in  NCHAN*PAYLOAD_W  channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]; word 0 is the low BEAT_W bits.
- method_rdy  out  NCHAN  channel i can accept a call (its holding register is empty).
- pipe_enq_ena  out  1  output beat valid.
- pipe_enq_v  out  BEAT_W  output beat data.
- pipe_enq_rdy  in  1  downstream accepts the beat.
- overflow  out  1  sticky: set when a strobe arrives while that channel's method_rdy is 0.

Behaviour:
- Reset (synchronous, RST=1 at an edge) values:
  - pipe_enq_ena=0, pipe_enq_v=0, overflow=0.
  - All pending bits clear, so method_rdy = all ones.
  - FSM in IDLE; round-robin pointer "last" = NCHAN-1, so channel 0 has first priority.
- Reset mid-message aborts the message. No further beats are issued, and partial messages are not resumed.
- Capture:
  - When method_ena[i] && method_rdy[i] at an edge, method_data slice i is latched and pending[i] is set.
  - method_rdy[i] = ~pending[i], combinationally from registered state.
  - A strobe with method_rdy[i]=0 is ignored and sets overflow.
- Header beat format:
  - bits[15:0] = channel index.
  - bits[31:16] = CHAN_WORDS[i]+1 (total beats, including the header).
  - Remaining bits are zero.
- Payload beats follow the header, lowest word first.
- FSM:
  - IDLE: if any pending bit is set, grant the first pending channel scanning from last+1 with wrap-around. Load the header into the output register, set pipe_enq_ena=1, record sel and beat counter=0, go to SEND. If nothing is pending, remain in IDLE with pipe_enq_ena=0.
  - SEND, while pipe_enq_ena && !pipe_enq_rdy: hold pipe_enq_v and pipe_enq_ena stable; no change.
  - SEND, on a beat handshake with beats remaining: load payload word[counter], increment counter.
  - SEND, on the final handshake: clear pending[sel], set last=sel, pipe_enq_ena=0, return to IDLE.
  - A channel with CHAN_WORDS=0 sends the header only.
- Timing:
  - Latency is 2 cycles: a strobe accepted at edge k gives a header valid in cycle k+1 (after edge k+1), provided the block is IDLE with nothing else pending.
  - One idle cycle separates consecutive messages.
  - Peak throughput is one beat per cycle within a message.
- Simultaneous events:
  - pending[i] clears at the final-beat edge, so method_rdy[i] rises the cycle after. A strobe in that same cycle is an overflow.
  - Several channels strobing in the same cycle are all captured.
  - A strobe on a non-selected channel during SEND is captured normally.
- pipe_enq_v is driven only from registered state, with no combinational path from inputs to the pipe outputs.

Test Plan:
- Single call: NCHAN=3, ch0 strobe with data word0=0xDEADBEEF, pipe_enq_rdy=1. Two cycles later the beats are 0x00020000 then 0xDEADBEEF. method_rdy[0] returns to 1 the cycle after the last beat.
- Multi-beat with backpressure: ch2 words {0x11,0x22,0x33}, pipe_enq_rdy low for 3 cycles on the second beat. Sequence 0x00040002, 0x11, 0x22, 0x33 with 0x11 held stable throughout the stall.
- Round-robin: all three channels strobe in the same cycle. Headers appear in channel order 0,1,2. Re-strobe ch0 and ch1 while ch2 is sending: ch0 follows, then ch1.
- Overflow: strobe ch1 twice on consecutive cycles while the pipe is blocked. The second strobe is dropped and overflow=1 until RST. Only one ch1 message is emitted.
- Reset mid-message: assert RST during beat 2 of a ch2 message. The next cycle shows pipe_enq_ena=0, method_rdy=3'b111, overflow=0. A subsequent ch0 call emits a clean message.
- Zero-length channel (CHAN_WORDS byte=0): one header beat with length 1, then IDLE.
